// File: rtl/port_pkg.sv
// Shared definitions for the egress-port read frontend.
//   ing_state_t / St*  : ingress FSM state encoding (Idle=0, Armed=1, InPkt=2)
//   beat_tag_t         : per-beat packet tags {eop, sop}, upper bits of a stored beat
//   cnt_width()        : occupancy counter width for a FIFO of a given depth
package port_pkg;

  typedef logic [1:0] ing_state_t;

  localparam ing_state_t StIdle  = 2'd0;
  localparam ing_state_t StArmed = 2'd1;
  localparam ing_state_t StInPkt = 2'd2;

  typedef struct packed {
    logic eop;
    logic sop;
  } beat_tag_t;

  localparam int unsigned BeatTagW = 2;

  // Occupancy needs one more bit than the address so that "full" is representable.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with register-array storage.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request and data; ignored when full unless popping
//   pop        : read request; ignored when empty
//   rdata      : head entry, valid whenever !empty
//   full/empty : occupancy flags
//   count      : current occupancy
module sync_fifo_fwft
  import port_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a write.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; the consumer gates rdata with !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/port_rd_frontend_fifo.sv
// Read-side frontend for one egress port: tags backend beats with sop/eop, buffers them
// in an elastic FIFO and drains them under a ready/valid handshake.
//   clk, rst          : clock, synchronous active-high reset
//   out_ready         : backend marks the next valid beat as a packet start
//   out_data_vld/out_data/end_of_packet : backend beat
//   fe_afull          : registered throttle back to the backend
//   rd_vld/rd_ready/rd_data/rd_sop/rd_eop : downstream beat handshake
//   pkt_cnt           : packets drained (eop accepted), wraps
//   ovf_cnt           : beats dropped on a full FIFO, saturates
//   proto_err         : sticky backend protocol violation flag
module port_rd_frontend_fifo
  import port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned AFULL_MARGIN = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  out_ready,
  input  logic                  out_data_vld,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic                  end_of_packet,
  output logic                  fe_afull,
  output logic                  rd_vld,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  ovf_cnt,
  output logic                  proto_err
);

  localparam int unsigned EntryW   = DATA_WIDTH + BeatTagW;
  localparam int unsigned FifoCntW = cnt_width(FIFO_DEPTH);

  typedef struct packed {
    beat_tag_t             tag;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  ing_state_t state_q, state_d, state_eff;
  logic       beat_acc, err_set;
  beat_t      in_beat, head;

  logic                fifo_full, fifo_empty;
  logic [FifoCntW-1:0] fifo_count, count_next;
  logic [EntryW-1:0]   fifo_rdata;
  logic                pop_fire, push_ok, drop;

  logic                 afull_q, proto_err_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, ovf_cnt_q;

  // Ingress FSM. out_ready always re-arms before the beat of the same cycle is
  // classified, so a same-cycle beat becomes the sop beat (also on a mid-packet restart).
  always_comb begin
    state_eff         = out_ready ? StArmed : state_q;
    err_set           = out_ready && (state_q != StIdle);
    beat_acc          = 1'b0;
    state_d           = state_eff;
    in_beat.data      = out_data;
    in_beat.tag.sop   = (state_eff == StArmed);
    in_beat.tag.eop   = end_of_packet;
    if (out_data_vld) begin
      if (state_eff == StIdle) begin
        err_set = 1'b1;
      end else begin
        beat_acc = 1'b1;
        state_d  = end_of_packet ? StIdle : StInPkt;
      end
    end
  end

  assign pop_fire = rd_vld && rd_ready;
  assign push_ok  = beat_acc && (!fifo_full || pop_fire);
  assign drop     = beat_acc && !push_ok;

  always_comb begin
    count_next = fifo_count + FifoCntW'(push_ok) - FifoCntW'(pop_fire);
  end

  sync_fifo_fwft #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (in_beat),
    .pop   (pop_fire),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      afull_q     <= 1'b0;
      proto_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      afull_q     <= (FIFO_DEPTH - 32'(count_next)) <= AFULL_MARGIN;
      proto_err_q <= proto_err_q | err_set;
      if (pop_fire && head.tag.eop) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
      if (drop && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign head    = fifo_rdata;
  assign rd_vld  = !fifo_empty;
  // Gate the unreset storage so idle outputs read as zero.
  assign rd_data = rd_vld ? head.data : '0;
  assign rd_sop  = rd_vld && head.tag.sop;
  assign rd_eop  = rd_vld && head.tag.eop;

  assign fe_afull  = afull_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_port_rd_frontend_fifo.sv
module tb_port_rd_frontend_fifo;

  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          out_ready = 1'b0, out_data_vld = 1'b0, end_of_packet = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic          fe_afull, rd_vld, rd_sop, rd_eop, proto_err;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] pkt_cnt, ovf_cnt;

  port_rd_frontend_fifo #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_MARGIN (MARGIN),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .out_ready     (out_ready),
    .out_data_vld  (out_data_vld),
    .out_data      (out_data),
    .end_of_packet (end_of_packet),
    .fe_afull      (fe_afull),
    .rd_vld        (rd_vld),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_sop        (rd_sop),
    .rd_eop        (rd_eop),
    .pkt_cnt       (pkt_cnt),
    .ovf_cnt       (ovf_cnt),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  // Reference model: packet-level view of the frontend.
  beat_t mq[$];     // beats the model holds in the buffer
  beat_t exp_q[$];  // scoreboard of beats expected downstream, in order
  int    m_state;   // 0 idle, 1 armed, 2 inside a packet
  int    m_pkt, m_ovf;
  bit    m_err, m_afull, started;
  int    n_chk, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit    full, pop, acc;
    int    eff;
    beat_t b;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_state = 0;
      m_pkt   = 0;
      m_ovf   = 0;
      m_err   = 0;
      m_afull = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = rd_ready && (mq.size() != 0);
      eff  = out_ready ? 1 : m_state;
      if (out_ready && m_state != 0) m_err = 1;
      acc = 0;
      if (out_data_vld) begin
        if (eff == 0) begin
          m_err = 1;
        end else begin
          acc    = 1;
          b.data = out_data;
          b.sop  = (eff == 1);
          b.eop  = end_of_packet;
          eff    = end_of_packet ? 0 : 2;
        end
      end
      m_state = eff;
      if (pop) begin
        if (mq[0].eop) m_pkt = (m_pkt + 1) % 65536;
        void'(mq.pop_front());
      end
      if (acc) begin
        if (!full || pop) begin
          mq.push_back(b);
          exp_q.push_back(b);
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
      end
      m_afull = (DEPTH - mq.size()) <= MARGIN;
    end
    started = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compares DUT status each cycle and pops the scoreboard on every handshake.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (started) begin
      chk("rd_vld", 32'(rd_vld), 32'(mq.size() != 0));
      chk("fe_afull", 32'(fe_afull), 32'(m_afull));
      chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      chk("proto_err", 32'(proto_err), 32'(m_err));
      if (rd_vld) begin
        if (rd_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h expected none at %0t", rd_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e.data));
            chk("rd_sop", 32'(rd_sop), 32'(e.sop));
            chk("rd_eop", 32'(rd_eop), 32'(e.eop));
          end
        end
      end else begin
        chk("idle_out", {14'd0, rd_data, rd_sop, rd_eop}, 32'd0);
      end
    end
  end

  task automatic drive(input bit rdy, input bit dv, input bit eop, input logic [DW-1:0] d,
                       input bit rr);
    out_ready     = rdy;
    out_data_vld  = dv;
    end_of_packet = eop;
    out_data      = d;
    rd_ready      = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, rr);
  endtask

  initial begin
    int len;
    bit rr;
    n_chk = 0;
    n_fail = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    idle(2, 1);

    // Basic 4-beat packet with rd_ready high.
    drive(1, 0, 0, '0, 1);
    for (int i = 1; i <= 4; i++) drive(0, 1, i == 4, DW'(i), 1);
    idle(3, 1);

    // Backpressure: 6 beats held, then drained.
    drive(1, 0, 0, '0, 0);
    for (int i = 1; i <= 6; i++) drive(0, 1, i == 6, DW'(16'h10 + i), 0);
    idle(2, 0);
    idle(8, 1);

    // Overflow: 10 beats into an 8-deep buffer.
    drive(1, 0, 0, '0, 0);
    for (int i = 1; i <= 10; i++) drive(0, 1, i == 10, DW'(16'h20 + i), 0);
    idle(2, 0);
    idle(10, 1);

    // Single-beat packet with arm and beat in the same cycle.
    drive(1, 1, 1, 16'hABCD, 1);
    idle(2, 1);

    // Protocol errors: stray beat, then out_ready mid-packet.
    drive(0, 1, 0, 16'h0BAD, 1);
    idle(2, 1);
    drive(1, 0, 0, '0, 1);
    drive(0, 1, 0, 16'h0031, 1);
    drive(0, 1, 0, 16'h0032, 1);
    drive(1, 0, 0, '0, 1);
    drive(0, 1, 1, 16'h0033, 1);
    idle(2, 1);

    // Reset mid-packet, then a clean packet.
    drive(1, 0, 0, '0, 0);
    for (int i = 1; i <= 3; i++) drive(0, 1, 0, DW'(16'h40 + i), 0);
    rst = 1;
    idle(1, 0);
    rst = 0;
    idle(1, 1);
    drive(1, 0, 0, '0, 1);
    for (int i = 1; i <= 3; i++) drive(0, 1, i == 3, DW'(16'h50 + i), 1);
    idle(3, 1);

    // Randomized packets with random backpressure and occasional faults/resets.
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1;
        idle(1, 1);
        rst = 0;
      end
      if ($urandom_range(0, 19) == 0) drive(0, 1, 0, DW'($urandom), 1);
      len = $urandom_range(1, 7);
      rr  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) drive(1, 0, 0, '0, rr);
      for (int i = 0; i < len; i++) begin
        rr = ($urandom_range(0, 2) != 0);
        if (i > 0 && $urandom_range(0, 29) == 0) drive(1, 0, 0, '0, rr);
        while ($urandom_range(0, 3) == 0) drive(0, 0, 0, '0, ($urandom_range(0, 2) != 0));
        drive(i == 0 && $urandom_range(0, 1) == 1, 1, i == len - 1, DW'($urandom), rr);
      end
    end

    idle(DEPTH + 4, 1);
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/port_rd_frontend_fifo.md
Name: port_rd_frontend_fifo

Overview:
Parametrised read-side frontend for one egress port. It sits between the port read backend and the external read interface. Backend beats are tagged with start/end-of-packet, held in a small elastic FIFO, and drained under a downstream ready handshake. Unlike the fixed 16-bit pass-through frontend, it adds:
- downstream backpressure (rd_ready);
- an almost-full throttle back to the backend;
- protocol checking;
- packet/overflow statistics.

Parameters:
DATA_WIDTH, 16, width of out_data / rd_data.
FIFO_DEPTH, 8, beat entries in the elastic FIFO; power of two, >= 4.
AFULL_MARGIN, 2, fe_afull asserts when free entries <= AFULL_MARGIN.
CNT_WIDTH, 16, width of the statistics counters.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
out_ready  input  1  backend: next out_data_vld beat is the first beat of a packet.
out_data_vld  input  1  backend beat valid.
out_data  input  DATA_WIDTH  backend beat data.
end_of_packet  input  1  backend: current valid beat is the last of the packet (qualified by out_data_vld).
fe_afull  output  1  throttle to backend; backend stops issuing beats while high.
rd_vld  output  1  output beat valid.
rd_ready  input  1  downstream accepts beat when rd_vld && rd_ready.
rd_data  output  DATA_WIDTH  output beat data.
rd_sop  output  1  first beat of packet, aligned with rd_vld.
rd_eop  output  1  last beat of packet, aligned with rd_vld.
pkt_cnt  output  CNT_WIDTH  packets fully drained (eop beat accepted downstream); wraps.
ovf_cnt  output  CNT_WIDTH  beats dropped because the FIFO was full; saturates at all-ones.
proto_err  output  1  sticky; set on a backend protocol violation.

Behaviour:
- Reset values: rd_vld=0, rd_sop=0, rd_eop=0, rd_data=0, fe_afull=0, pkt_cnt=0, ovf_cnt=0, proto_err=0. FIFO is emptied and the ingress FSM goes to IDLE.
- Reset mid-packet discards all stored beats. No eop is emitted for the discarded packet.
- Ingress FSM states: IDLE, ARMED, IN_PKT.
  - IDLE + out_ready -> ARMED.
  - ARMED + out_data_vld -> push beat with sop=1. If end_of_packet is also high, tag eop=1 and go to IDLE; otherwise go to IN_PKT.
  - IN_PKT + out_data_vld -> push beat with sop=0 and eop=end_of_packet. end_of_packet -> IDLE.
  - out_ready and out_data_vld in the same cycle while IDLE: ARMED takes effect first, so this beat is the sop beat.
- Protocol errors (each sets proto_err; the FSM state is unchanged unless stated):
  - out_data_vld while IDLE: the beat is dropped.
  - out_ready while ARMED or IN_PKT: if IN_PKT, the FSM restarts to ARMED. No eop is synthesised.
- FIFO:
  - Entry width DATA_WIDTH+2 ({eop, sop, data}); count width clog2(FIFO_DEPTH)+1.
  - Push happens when a beat is accepted by the FSM. Pop happens when rd_vld && rd_ready.
  - Simultaneous push and pop while full is allowed; occupancy is unchanged and the beat is not dropped.
  - Push while full without a pop: the beat is dropped and ovf_cnt increments. An FSM transition on a dropped eop still occurs, so the packet ends truncated.
- Output:
  - First-word-fall-through, registered head.
  - Latency: a beat pushed in cycle N appears on rd_vld in cycle N+1 if the FIFO was empty and the output stage was free.
  - rd_data/rd_sop/rd_eop hold stable while rd_vld && !rd_ready.
  - With rd_ready held high, sustained throughput is 1 beat/cycle.
- fe_afull is registered from the next-state occupancy: high when FIFO_DEPTH - count_next <= AFULL_MARGIN.
- pkt_cnt increments on an accepted beat with eop=1.

Decomposition:
- Shared package port_pkg holds:
  - the beat struct {eop, sop, data};
  - the ingress FSM state enum (IDLE=0, ARMED=1, IN_PKT=2);
  - a clog2 helper constant.
- One natural sub-module: sync_fifo_fwft (parametrised width/depth, synchronous active-high reset, push/pop/full/empty/count).

Test Plan:
- Basic packet: out_ready, then 4 beats 0x0001..0x0004 with eop on the 4th, rd_ready=1 -> rd_vld on 4 consecutive cycles starting 1 cycle after the first beat; sop on 0x0001 only, eop on 0x0004 only; pkt_cnt=1.
- Backpressure: FIFO_DEPTH=8, rd_ready=0, push 6 beats -> fe_afull=1 the cycle after the 6th push; no data lost. Then rd_ready=1 -> 6 beats out in order, fe_afull drops when count<=5.
- Overflow: rd_ready=0, push 10 beats -> 8 stored, ovf_cnt=2. Drain -> exactly 8 beats out.
- Single-beat packet: out_ready and out_data_vld+end_of_packet in the same cycle, data 0xABCD -> one rd_vld beat with sop=eop=1; pkt_cnt increments.
- Protocol errors:
  - out_data_vld with no prior out_ready -> beat dropped, proto_err=1, no rd_vld.
  - out_ready mid-packet -> proto_err=1, the next beat carries sop.
- Reset mid-packet: 3 beats stored, rst for 1 cycle -> next cycle rd_vld=0, counters 0, proto_err=0. The next clean packet passes normally.
